zx_mem_pager: RTL and testbench

- Parametrised memory/IO controller for the Spectrum core.
- Replaces the fixed 48K decode with 128K-style paging of RAM and ROM, a ULA port-0xFE latch (border, beeper, mic), and a divided CPU clock enable.
- Sits between the tv80n bus signals and the ROM/RAM/keyboard/video blocks, and drives the CPU data-in mux.

---
 rtl/zx_mem_pager_if.sv | 21 ++
 rtl/zx_mem_pager.sv | 154 +++++++++++++++
 tb/tb_zx_mem_pager.sv | 304 ++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/zx_mem_pager_if.sv
// CPU-side bus bundle between the tv80n core and zx_mem_pager.
// master = CPU (drives address/strobes), slave = pager (returns read data).
interface zx_mem_pager_if;
  logic [15:0] cpu_addr;
  logic [7:0]  cpu_dout;
  logic        n_mreq;
  logic        n_iorq;
  logic        n_wr;
  logic        n_rd;
  logic [7:0]  cpu_din;

  modport master (
    output cpu_addr, cpu_dout, n_mreq, n_iorq, n_wr, n_rd,
    input  cpu_din
  );

  modport slave (
    input  cpu_addr, cpu_dout, n_mreq, n_iorq, n_wr, n_rd,
    output cpu_din
  );
endinterface

// File: rtl/zx_mem_pager.sv
// 128K-style memory/IO pager for the Spectrum core: ROM/RAM paging, ULA port 0xFE latch,
// divided CPU clock enable. Optional ULA contention stall enabled by `define ZX_CONTENTION_EN.
module zx_mem_pager #(
  parameter int RAM_BANKS = 8,
  parameter int ROM_PAGES = 2,
  parameter int CLK_DIV   = 8
) (
  input  logic                              clk,
  input  logic                              reset,
  zx_mem_pager_if.slave                     bus,
  input  logic [7:0]                        rom_data,
  input  logic [7:0]                        ram_data,
  input  logic [4:0]                        key_data,
  input  logic                              ear,
  input  logic                              vid_contend,
  output logic [14+$clog2(ROM_PAGES)-1:0]   rom_addr,
  output logic [14+$clog2(RAM_BANKS)-1:0]   ram_addr,
  output logic                              ram_we,
  output logic                              cpu_ce,
  output logic [2:0]                        border,
  output logic                              beeper,
  output logic                              mic,
  output logic                              scr_bank,
  output logic                              paging_locked
);

  localparam int BANK_W = $clog2(RAM_BANKS);
  localparam int CNT_W  = $clog2(CLK_DIV);
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(CLK_DIV - 1);

  logic [CNT_W-1:0]  ce_cnt;
  logic              stall;
  logic [BANK_W-1:0] bank;
  logic [BANK_W-1:0] ram_bank;
  logic              rom_page;
  logic              ws;
  logic              ws_q;
  logic              ws_rise;
  logic              sel_fe;
  logic              sel_7ffd;
  logic [3:0]        bank_wr;
  logic              io_rd;
  logic              mem_rd;

  assign ws       = !bus.n_iorq && !bus.n_wr;
  assign ws_rise  = ws && !ws_q;
  assign sel_fe   = !bus.cpu_addr[0];
  assign sel_7ffd = !bus.cpu_addr[15] && !bus.cpu_addr[1];
  assign bank_wr  = (RAM_BANKS == 16) ? {bus.cpu_dout[6], bus.cpu_dout[2:0]}
                                      : {1'b0, bus.cpu_dout[2:0]};

  // ws_q resets high so a write strobe still held across reset release is not seen as a new edge.
  always_ff @(posedge clk) begin
    if (reset) begin
      ce_cnt        <= '0;
      ws_q          <= 1'b1;
      bank          <= '0;
      rom_page      <= 1'b0;
      scr_bank      <= 1'b0;
      paging_locked <= 1'b0;
      border        <= '0;
      beeper        <= 1'b0;
      mic           <= 1'b0;
    end else begin
      ws_q <= ws;

      if (stall)
        ce_cnt <= CNT_MAX;
      else if (ce_cnt == CNT_MAX)
        ce_cnt <= '0;
      else
        ce_cnt <= ce_cnt + CNT_W'(1);

      if (ws_rise && sel_fe) begin
        border <= bus.cpu_dout[2:0];
        mic    <= bus.cpu_dout[3];
        beeper <= bus.cpu_dout[4];
      end

      if (ws_rise && sel_7ffd && !paging_locked) begin
        bank          <= bank_wr[BANK_W-1:0];
        scr_bank      <= bus.cpu_dout[3];
        rom_page      <= (ROM_PAGES > 1) ? bus.cpu_dout[4] : 1'b0;
        paging_locked <= bus.cpu_dout[5];
      end
    end
  end

`ifdef ZX_CONTENTION_EN
  logic contended;

  always_comb begin
    contended = 1'b0;
    if (!bus.n_mreq) begin
      if (bus.cpu_addr[15:14] == 2'b01)
        contended = 1'b1;
      else if (bus.cpu_addr[15:14] == 2'b11 && bank[0])
        contended = 1'b1;
    end
    stall = contended && vid_contend;
  end

  logic unused_cfg;
  assign unused_cfg = 1'b0;
`else
  assign stall = 1'b0;

  logic unused_cfg;
  assign unused_cfg = vid_contend;
`endif

  assign cpu_ce = (ce_cnt == CNT_MAX) && !stall;

  always_comb begin
    ram_bank = '0;
    unique case (bus.cpu_addr[15:14])
      2'b01:   ram_bank = BANK_W'(5);
      2'b10:   ram_bank = BANK_W'(2);
      2'b11:   ram_bank = bank;
      default: ram_bank = '0;
    endcase
  end

  assign ram_addr = {ram_bank, bus.cpu_addr[13:0]};
  assign ram_we   = !bus.n_mreq && !bus.n_wr && (bus.cpu_addr[15:14] != 2'b00);

  if (ROM_PAGES > 1) begin : g_rom_paged
    assign rom_addr = {rom_page, bus.cpu_addr[13:0]};
  end else begin : g_rom_flat
    assign rom_addr = bus.cpu_addr[13:0];
  end

  assign io_rd  = !bus.n_iorq && !bus.n_rd;
  assign mem_rd = !bus.n_mreq && !bus.n_rd;

  always_comb begin
    bus.cpu_din = 8'hFF;
    if (io_rd) begin
      if (!bus.cpu_addr[0])
        bus.cpu_din = {1'b1, ear, 1'b1, key_data};
      else
        bus.cpu_din = 8'hFF;
    end else if (mem_rd) begin
      if (bus.cpu_addr[15:14] == 2'b00)
        bus.cpu_din = rom_data;
      else
        bus.cpu_din = ram_data;
    end
  end

  logic unused_bits;
  assign unused_bits = &{1'b0, unused_cfg, bus.cpu_dout[7], bank_wr, rom_page};

endmodule

// File: tb/tb_zx_mem_pager.sv
// Self-checking bench for zx_mem_pager (default parameters), randomized stimulus against
// a behavioural model of the paging/port rules.
module tb_zx_mem_pager;
  localparam int RAM_BANKS = 8;
  localparam int ROM_PAGES = 2;
  localparam int CLK_DIV   = 8;

  logic        clk = 1'b0;
  logic        reset;
  logic [7:0]  rom_data, ram_data;
  logic [4:0]  key_data;
  logic        ear, vid_contend;
  logic [14:0] rom_addr;
  logic [16:0] ram_addr;
  logic        ram_we, cpu_ce, beeper, mic, scr_bank, paging_locked;
  logic [2:0]  border;

  zx_mem_pager_if bus ();

  zx_mem_pager #(.RAM_BANKS(RAM_BANKS), .ROM_PAGES(ROM_PAGES), .CLK_DIV(CLK_DIV)) dut (
    .clk(clk), .reset(reset), .bus(bus),
    .rom_data(rom_data), .ram_data(ram_data), .key_data(key_data), .ear(ear),
    .vid_contend(vid_contend), .rom_addr(rom_addr), .ram_addr(ram_addr), .ram_we(ram_we),
    .cpu_ce(cpu_ce), .border(border), .beeper(beeper), .mic(mic), .scr_bank(scr_bank),
    .paging_locked(paging_locked)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  // Behavioural model state
  int m_bank, m_scr, m_rom, m_lock, m_border, m_beeper, m_mic;

  task automatic model_reset();
    m_bank = 0; m_scr = 0; m_rom = 0; m_lock = 0;
    m_border = 0; m_beeper = 0; m_mic = 0;
  endtask

  task automatic model_io_write(input int a, input int d);
    if (a % 2 == 0) begin
      m_border = d % 8;
      m_mic    = (d / 8) % 2;
      m_beeper = (d / 16) % 2;
    end
    if (a < 32768 && (a / 2) % 2 == 0 && m_lock == 0) begin
      m_bank = (RAM_BANKS == 16) ? (d % 8) + 8 * ((d / 64) % 2) : d % 8;
      m_scr  = (d / 8) % 2;
      m_rom  = (ROM_PAGES == 2) ? (d / 16) % 2 : 0;
      m_lock = (d / 32) % 2;
    end
  endtask

  function automatic int exp_ram_addr(input int a);
    int region, b;
    region = a / 16384;
    b = (region == 1) ? 5 : (region == 2) ? 2 : (region == 3) ? m_bank : 0;
    return b * 16384 + a % 16384;
  endfunction

  function automatic int exp_rom_addr(input int a);
    return m_rom * 16384 + a % 16384;
  endfunction

  function automatic int exp_io_din(input int a);
    if (a % 2 == 0) return 128 + 64 * int'(ear) + 32 + int'(key_data);
    return 255;
  endfunction

  task automatic bus_idle();
    bus.cpu_addr = 16'h0000; bus.cpu_dout = 8'h00;
    bus.n_mreq = 1'b1; bus.n_iorq = 1'b1; bus.n_wr = 1'b1; bus.n_rd = 1'b1;
  endtask

  task automatic do_reset();
    @(posedge clk); #1 reset = 1'b1; bus_idle();
    @(posedge clk); @(posedge clk); #1 reset = 1'b0;
    model_reset();
  endtask

  task automatic do_io_write(input logic [15:0] a, input logic [7:0] d, input int hold);
    @(posedge clk); #1;
    bus.cpu_addr = a; bus.cpu_dout = d; bus.n_iorq = 1'b0; bus.n_wr = 1'b0;
    repeat (hold) @(posedge clk);
    #1 bus.n_iorq = 1'b1; bus.n_wr = 1'b1;
    model_io_write(int'(a), int'(d));
  endtask

  task automatic test_reset();
    do_reset();
    @(posedge clk); #1 reset = 1'b1; bus.cpu_addr = 16'hC005;
    @(negedge clk);
    n_checks++; if ({border, beeper, mic} !== 5'b0) begin n_fail++; $display("FAIL reset_ula got=%b want=00000", {border, beeper, mic}); end
    n_checks++; if ({scr_bank, paging_locked} !== 2'b00) begin n_fail++; $display("FAIL reset_paging got=%b want=00", {scr_bank, paging_locked}); end
    n_checks++; if (cpu_ce !== 1'b0) begin n_fail++; $display("FAIL reset_ce got=%b want=0", cpu_ce); end
    n_checks++; if (ram_addr !== 17'h00005) begin n_fail++; $display("FAIL reset_bank got=%h want=00005", ram_addr); end
    #1 bus.cpu_addr = 16'h0005;
    #1;
    n_checks++; if (rom_addr !== 15'h0005) begin n_fail++; $display("FAIL reset_rom_page got=%h want=0005", rom_addr); end
    @(posedge clk); #1 reset = 1'b0; model_reset(); bus_idle();
  endtask

  task automatic test_clock_enable();
    do_reset();
    // Period 1 after release holds counter 0; pulses land in periods CLK_DIV, 2*CLK_DIV, ...
    for (int cyc = 1; cyc <= 5 * CLK_DIV; cyc++) begin
      @(negedge clk);
      n_checks++;
      if (cpu_ce !== ((cyc % CLK_DIV) == 0)) begin
        n_fail++; $display("FAIL cpu_ce cyc=%0d got=%b want=%b", cyc, cpu_ce, (cyc % CLK_DIV) == 0);
      end
    end
  endtask

  task automatic test_ula_port();
    do_reset();
    @(posedge clk); #1;
    bus.cpu_addr = 16'h00FE; bus.cpu_dout = 8'h15; bus.n_iorq = 1'b0; bus.n_wr = 1'b0;
    @(negedge clk);
    n_checks++; if (border !== 3'd0) begin n_fail++; $display("FAIL ula_latency got=%0d want=0", border); end
    @(posedge clk); #1;
    model_io_write(16'h00FE, 8'h15);
    bus.cpu_dout = 8'h0A;
    @(negedge clk);
    n_checks++; if ({border, beeper, mic} !== {3'(m_border), 1'(m_beeper), 1'(m_mic)}) begin
      n_fail++; $display("FAIL ula_commit got=%b want=%b", {border, beeper, mic}, {3'(m_border), 1'(m_beeper), 1'(m_mic)}); end
    repeat (3) @(posedge clk);
    #1 bus.n_iorq = 1'b1; bus.n_wr = 1'b1;
    @(negedge clk);
    n_checks++; if ({border, beeper, mic} !== 5'b101_1_0) begin
      n_fail++; $display("FAIL ula_single_commit got=%b want=10110", {border, beeper, mic}); end
  endtask

  task automatic test_paging();
    do_reset();
    do_io_write(16'h7FFD, 8'h13, 2);
    @(posedge clk); #1; rom_data = 8'h3C; ram_data = 8'hA5;
    bus.cpu_addr = 16'hC123; bus.n_mreq = 1'b0; bus.n_rd = 1'b0;
    @(negedge clk);
    n_checks++; if (ram_addr !== 17'h0C123) begin n_fail++; $display("FAIL paging_ram got=%h want=0C123", ram_addr); end
    n_checks++; if (bus.cpu_din !== 8'hA5) begin n_fail++; $display("FAIL paging_ram_din got=%h want=A5", bus.cpu_din); end
    n_checks++; if (scr_bank !== 1'(m_scr)) begin n_fail++; $display("FAIL paging_scr got=%b want=%0d", scr_bank, m_scr); end
    @(posedge clk); #1 bus.cpu_addr = 16'h0001;
    @(negedge clk);
    n_checks++; if (rom_addr !== 15'h4001) begin n_fail++; $display("FAIL paging_rom got=%h want=4001", rom_addr); end
    n_checks++; if (bus.cpu_din !== 8'h3C) begin n_fail++; $display("FAIL paging_rom_din got=%h want=3C", bus.cpu_din); end
    @(posedge clk); #1 bus_idle();
  endtask

  task automatic test_lock();
    do_reset();
    do_io_write(16'h7FFD, 8'h21, 1);
    do_io_write(16'h7FFD, 8'h07, 1);
    do_io_write(16'h00FE, 8'h02, 1);
    @(posedge clk); #1 bus.cpu_addr = 16'hC000;
    @(negedge clk);
    n_checks++; if (ram_addr !== 17'h04000) begin n_fail++; $display("FAIL lock_bank got=%h want=04000", ram_addr); end
    n_checks++; if (paging_locked !== 1'b1) begin n_fail++; $display("FAIL lock_state got=%b want=1", paging_locked); end
    n_checks++; if (border !== 3'd2) begin n_fail++; $display("FAIL lock_fe_still_works got=%0d want=2", border); end
    do_reset();
    @(posedge clk); #1 bus.cpu_addr = 16'hC000;
    @(negedge clk);
    n_checks++; if ({ram_addr, paging_locked} !== {17'h00000, 1'b0}) begin
      n_fail++; $display("FAIL lock_cleared got=%h/%b want=00000/0", ram_addr, paging_locked); end
  endtask

  task automatic test_dual_port();
    do_reset();
    do_io_write(16'h7FFC, 8'h17, 1);
    @(posedge clk); #1 bus.cpu_addr = 16'hFFFF;
    @(negedge clk);
    n_checks++; if ({border, beeper, mic} !== {3'(m_border), 1'(m_beeper), 1'(m_mic)}) begin
      n_fail++; $display("FAIL dual_ula got=%b want=%b", {border, beeper, mic}, {3'(m_border), 1'(m_beeper), 1'(m_mic)}); end
    n_checks++; if (ram_addr !== 17'(exp_ram_addr(16'hFFFF))) begin
      n_fail++; $display("FAIL dual_bank got=%h want=%h", ram_addr, 17'(exp_ram_addr(16'hFFFF))); end
  endtask

  task automatic test_read_mux();
    do_reset();
    @(posedge clk); #1 key_data = 5'h1E; ear = 1'b1;
    bus.cpu_addr = 16'h00FE; bus.n_iorq = 1'b0; bus.n_rd = 1'b0;
    @(negedge clk);
    n_checks++; if (bus.cpu_din !== 8'hFE) begin n_fail++; $display("FAIL in_fe got=%h want=FE", bus.cpu_din); end
    @(posedge clk); #1 bus.cpu_addr = 16'h7FFD;
    @(negedge clk);
    n_checks++; if (bus.cpu_din !== 8'hFF) begin n_fail++; $display("FAIL in_7ffd got=%h want=FF", bus.cpu_din); end
    for (int i = 0; i < 6; i++) begin
      @(posedge clk); #1 key_data = 5'($urandom); ear = 1'($urandom); bus.cpu_addr = {8'($urandom), 7'($urandom), 1'b0};
      @(negedge clk);
      n_checks++; if (bus.cpu_din !== 8'(exp_io_din(int'(bus.cpu_addr)))) begin
        n_fail++; $display("FAIL in_keys got=%h want=%h", bus.cpu_din, 8'(exp_io_din(int'(bus.cpu_addr)))); end
    end
    @(posedge clk); #1 bus_idle(); bus.cpu_addr = 16'h0000; rom_data = 8'h12;
    @(negedge clk);
    n_checks++; if (bus.cpu_din !== 8'hFF) begin n_fail++; $display("FAIL no_read got=%h want=FF", bus.cpu_din); end
  endtask

  task automatic test_reset_mid_io();
    do_reset();
    do_io_write(16'h00FE, 8'h03, 1);
    @(posedge clk); #1 reset = 1'b1;
    bus.cpu_addr = 16'h00FE; bus.cpu_dout = 8'h17; bus.n_iorq = 1'b0; bus.n_wr = 1'b0;
    @(posedge clk); #1 reset = 1'b0; model_reset();
    repeat (3) @(posedge clk);
    #1 bus.n_iorq = 1'b1; bus.n_wr = 1'b1;
    @(negedge clk);
    n_checks++; if ({border, beeper, mic} !== 5'b0) begin
      n_fail++; $display("FAIL reset_mid_io got=%b want=00000", {border, beeper, mic}); end
  endtask

  task automatic test_random();
    logic [15:0] a;
    logic [7:0]  d;
    int          op;
    do_reset();
    for (int i = 0; i < 80; i++) begin
      op = $urandom_range(0, 3);
      a  = 16'($urandom);
      d  = 8'($urandom);
      if (op == 0) begin
        if ($urandom_range(0, 7) != 0) d[5] = 1'b0;
        do_io_write(a, d, $urandom_range(1, 4));
        @(negedge clk);
        n_checks++; if ({border, beeper, mic, scr_bank, paging_locked} !==
                        {3'(m_border), 1'(m_beeper), 1'(m_mic), 1'(m_scr), 1'(m_lock)}) begin
          n_fail++; $display("FAIL rnd_regs a=%h d=%h got=%b want=%b", a, d, {border, beeper, mic, scr_bank, paging_locked},
                             {3'(m_border), 1'(m_beeper), 1'(m_mic), 1'(m_scr), 1'(m_lock)}); end
      end else begin
        @(posedge clk); #1;
        rom_data = 8'($urandom); ram_data = 8'($urandom); key_data = 5'($urandom); ear = 1'($urandom);
        bus.cpu_addr = a; bus.cpu_dout = d;
        bus.n_mreq = (op == 3); bus.n_iorq = (op != 3); bus.n_rd = (op == 2); bus.n_wr = (op != 2);
        @(negedge clk);
        if (op == 1) begin
          n_checks++;
          if (a[15:14] == 2'b00) begin
            if ({rom_addr, bus.cpu_din} !== {15'(exp_rom_addr(int'(a))), rom_data}) begin
              n_fail++; $display("FAIL rnd_rom a=%h got=%h/%h want=%h/%h", a, rom_addr, bus.cpu_din, 15'(exp_rom_addr(int'(a))), rom_data); end
          end else begin
            if ({ram_addr, bus.cpu_din} !== {17'(exp_ram_addr(int'(a))), ram_data}) begin
              n_fail++; $display("FAIL rnd_ram a=%h got=%h/%h want=%h/%h", a, ram_addr, bus.cpu_din, 17'(exp_ram_addr(int'(a))), ram_data); end
          end
        end else if (op == 2) begin
          n_checks++; if (ram_we !== (a >= 16'h4000)) begin
            n_fail++; $display("FAIL rnd_we a=%h got=%b want=%b", a, ram_we, a >= 16'h4000); end
        end else begin
          n_checks++; if (bus.cpu_din !== 8'(exp_io_din(int'(a)))) begin
            n_fail++; $display("FAIL rnd_in a=%h got=%h want=%h", a, bus.cpu_din, 8'(exp_io_din(int'(a)))); end
        end
        @(posedge clk); #1 bus_idle();
      end
    end
  endtask

  task automatic test_contention();
    int pulses;
    do_reset();
    @(posedge clk); #1;
    bus.cpu_addr = 16'h4000; bus.n_mreq = 1'b0; bus.n_rd = 1'b0; vid_contend = 1'b1;
`ifdef ZX_CONTENTION_EN
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      n_checks++; if (cpu_ce !== 1'b0) begin n_fail++; $display("FAIL contend_hold i=%0d got=%b want=0", i, cpu_ce); end
    end
    @(posedge clk); #1 vid_contend = 1'b0;
    @(negedge clk);
    n_checks++; if (cpu_ce !== 1'b1) begin n_fail++; $display("FAIL contend_release got=%b want=1", cpu_ce); end
`else
    pulses = 0;
    for (int i = 0; i < 3 * CLK_DIV; i++) begin
      @(negedge clk);
      if (cpu_ce === 1'b1) pulses++;
    end
    n_checks++; if (pulses != 3) begin n_fail++; $display("FAIL contend_ignored got=%0d want=3", pulses); end
`endif
    @(posedge clk); #1 bus_idle(); vid_contend = 1'b0;
  endtask

  initial begin
    reset = 1'b1; vid_contend = 1'b0; key_data = 5'h1F; ear = 1'b0;
    rom_data = 8'h00; ram_data = 8'h00;
    bus_idle();
    model_reset();
    test_reset();
    test_clock_enable();
    test_ula_port();
    test_paging();
    test_lock();
    test_dual_port();
    test_read_mux();
    test_reset_mid_io();
    test_random();
    test_contention();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL timeout got=running want=finished");
    $fatal(1, "timeout");
  end
endmodule
